hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MUL_CYCLES, default 4, multiply busy length in cycles.
REQ-002 Parameter DIV_CYCLES, default 32, divide busy length in cycles.
REQ-003 clk  in  1  pipeline clock; all state updates on the falling edge, same edge as the stage registers.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 ifid_instr  in  32  instruction held in IF/ID; rs=[25:21], rt=[20:16], opcode=[31:26], funct=[5:0].
REQ-006 idex_memread  in  3  ID/EX load type; nonzero means a load is in EX.
REQ-007 idex_rt  in  5  ID/EX rt, the load destination.
REQ-008 idex_jump  in  1  jump in EX.
REQ-009 exmem_branch, exmem_zero  in  1 each  branch in MEM and its zero flag.
REQ-010 md_start  in  1  mult/multu/div/divu in EX this cycle.
REQ-011 md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply.
REQ-012 pc_wr  out  1  PC write enable.
REQ-013 ifid_wr  out  1  drives the IF/ID wr input.
REQ-014 ifid_flush  out  1  drives the IF/ID flush input.
REQ-015 idex_bubble  out  1  zeroes control fields entering ID/EX.
REQ-016 exmem_bubble  out  1  zeroes control fields entering EX/MEM.
REQ-017 md_busy  out  1  multiply/divide unit busy.
REQ-018 md_done  out  1  one-cycle pulse; HI_Wr/LO_Wr qualifier.
REQ-019 stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-020 branch_taken = exmem_branch & exmem_zero. It asserts ifid_flush, idex_bubble and exmem_bubble in the same cycle, with pc_wr=1.
REQ-021 idex_jump (without branch_taken) asserts ifid_flush and idex_bubble, with exmem_bubble=0 and pc_wr=1.
REQ-022 load_use = (idex_memread != 0) & (idex_rt != 0) & (idex_rt == rs | idex_rt == rt).
REQ-023 md_hazard = md_busy & opcode == 0 & funct in 0x10..0x1B (mfhi, mthi, mflo, mtlo, mult, multu, div, divu).
REQ-024 Stall (load_use or md_hazard) drives pc_wr=0, ifid_wr=0, idex_bubble=1, ifid_flush=0.
REQ-025 Priority is branch_taken > idex_jump > stall. A flush overrides a simultaneous stall, and ifid_wr is then 1.
REQ-026 With no event: pc_wr=1, ifid_wr=1, all flush/bubble outputs 0.
REQ-027 Outputs are combinational from inputs and registered state. There is zero-cycle latency from hazard to control.
REQ-028 The MD FSM has states IDLE, MUL, DIV, DONE.
REQ-029 IDLE with md_start: go to MUL or DIV, loading the counter with (CYCLES-1).
REQ-030 MUL/DIV: decrement the counter each edge; at counter 0, go to DONE.
REQ-031 DONE lasts one cycle, then returns to IDLE.
REQ-032 md_busy = state in {MUL, DIV}; md_done = (state == DONE).
REQ-033 md_start is ignored outside IDLE.
REQ-034 md_start is ignored in any cycle where branch_taken = 1, because the EX instruction is squashed.
REQ-035 A load_use stall does not freeze the MD FSM, and md_hazard does not restart it.
REQ-036 stall_cnt increments on each edge where the stall in REQ-024 is in effect.
REQ-037 flush_cnt increments on each edge where ifid_flush = 1.
REQ-038 Both counters saturate at 0xFFFF; there is no wrap.

Reset
REQ-039 rst low immediately forces: MD state IDLE, counter 0, stall_cnt = flush_cnt = 0, md_busy = md_done = 0.
REQ-040 While rst is low, all flush/bubble outputs are held at 0 and pc_wr = ifid_wr = 1.
REQ-041 Reset asserted mid-multiply/divide abandons the operation with no md_done pulse.
REQ-042 After rst returns high, the first falling edge behaves per Function.

Structure
REQ-043 Package hazard_pkg holds: MD state encoding, opcode/funct constants (SPECIAL = 0, funct 0x10..0x1B), and default MUL_CYCLES/DIV_CYCLES.
REQ-044 The MD FSM and its counter form one sub-module, md_seq.
REQ-045 md_seq has inputs clk, rst, start, is_div and outputs busy, done.
REQ-046 Hazard decode, priority logic and performance counters stay in hazard_unit.

Verification
REQ-047 Load-use: idex_memread = 3'b001, idex_rt = 8, ifid_instr rs = 8 -> pc_wr=0, ifid_wr=0, idex_bubble=1 for 1 cycle, stall_cnt = 1.
REQ-048 idex_rt = 0 with rs = 0, or idex_memread = 0 -> no stall.
REQ-049 Branch vs stall: branch_taken plus load_use in the same cycle -> ifid_flush=1, idex_bubble=1, exmem_bubble=1, pc_wr=1, flush_cnt+1, stall_cnt unchanged.
REQ-050 Multiply: md_start, md_is_div=0 -> md_busy high 4 cycles, then md_done high exactly 1 cycle.
REQ-051 Multiply with mflo (funct 0x12) in ID -> stalled every busy cycle and released in the DONE cycle.
REQ-052 Divide with reset: md_start, md_is_div=1; drop rst at cycle 10 -> md_busy=0 at once, no md_done, counters 0.
REQ-053 md_start during DIV -> ignored, and DIV still ends after 32 cycles.
REQ-054 Saturation: preload via 65,540 consecutive stall cycles -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: MD sequencer states,
// instruction field constants and default multiply/divide latencies.
package hazard_pkg;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdMul  = 2'd1,
    MdDiv  = 2'd2,
    MdDone = 2'd3
  } md_state_e;

  localparam logic [5:0] OpSpecial   = 6'h00;
  localparam logic [5:0] FunctMdLow  = 6'h10;  // mfhi
  localparam logic [5:0] FunctMdHigh = 6'h1B;  // divu

  localparam int unsigned DefMulCycles = 4;
  localparam int unsigned DefDivCycles = 32;

  // True for mfhi/mthi/mflo/mtlo/mult/multu/div/divu.
  function automatic logic is_md_instr(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OpSpecial) && (funct >= FunctMdLow) && (funct <= FunctMdHigh);
  endfunction

endpackage

// File: rtl/md_seq.sv
// Multiply/divide busy sequencer: counts out the unit latency and pulses
// done for one cycle. State advances on the falling clock edge.
module md_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = DefMulCycles,
  parameter int unsigned DIV_CYCLES = DefDivCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  md_state_e   state_q;
  logic [15:0] cnt_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        MdIdle: begin
          if (start) begin
            state_q <= is_div ? MdDiv : MdMul;
            cnt_q   <= is_div ? 16'(DIV_CYCLES - 1) : 16'(MUL_CYCLES - 1);
            busy    <= 1'b1;
          end
        end
        MdMul, MdDiv: begin
          if (cnt_q == '0) begin
            state_q <= MdDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        MdDone: begin
          state_q <= MdIdle;
          done    <= 1'b0;
        end
        default: begin
          state_q <= MdIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use / HI-LO stall detection, branch and jump
// flush priority, multiply/divide sequencing and saturating perf counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = DefMulCycles,
  parameter int unsigned DIV_CYCLES = DefDivCycles
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifid_instr,
  input  logic [2:0]  idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        idex_jump,
  input  logic        exmem_branch,
  input  logic        exmem_zero,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        pc_wr,
  output logic        ifid_wr,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [4:0] rs, rt;
  logic [5:0] opcode, funct;
  logic       unused_instr;
  logic       branch_taken, jump_taken, load_use, md_hazard, stall, stall_eff;

  assign opcode       = ifid_instr[31:26];
  assign rs           = ifid_instr[25:21];
  assign rt           = ifid_instr[20:16];
  assign funct        = ifid_instr[5:0];
  assign unused_instr = ^ifid_instr[15:6];

  // Outputs fall back to free-running values while reset is held.
  assign branch_taken = rst & exmem_branch & exmem_zero;
  assign jump_taken   = rst & idex_jump & ~branch_taken;
  assign load_use     = (idex_memread != 3'd0) && (idex_rt != 5'd0) &&
                        ((idex_rt == rs) || (idex_rt == rt));
  assign md_hazard    = md_busy & is_md_instr(opcode, funct);
  assign stall        = rst & (load_use | md_hazard);
  assign stall_eff    = stall & ~branch_taken & ~jump_taken;

  assign pc_wr        = ~stall_eff;
  assign ifid_wr      = ~stall_eff;
  assign ifid_flush   = branch_taken | jump_taken;
  assign idex_bubble  = branch_taken | jump_taken | stall_eff;
  assign exmem_bubble = branch_taken;

  // A taken branch squashes the EX instruction, including a pending md_start.
  md_seq #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md_seq (
    .clk   (clk),
    .rst   (rst),
    .start (md_start & ~branch_taken),
    .is_div(md_is_div),
    .busy  (md_busy),
    .done  (md_done)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_eff && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expected outputs are queued when each
// cycle's stimulus is applied and compared before the falling edge.
module tb_hazard_unit;

  logic        clk = 1'b1;
  logic        rst = 1'b0;
  logic [31:0] ifid_instr = '0;
  logic [2:0]  idex_memread = '0;
  logic [4:0]  idex_rt = '0;
  logic        idex_jump = 1'b0, exmem_branch = 1'b0, exmem_zero = 1'b0;
  logic        md_start = 1'b0, md_is_div = 1'b0;
  logic        pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_bubble, md_busy, md_done;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .ifid_instr  (ifid_instr),
    .idex_memread(idex_memread),
    .idex_rt     (idex_rt),
    .idex_jump   (idex_jump),
    .exmem_branch(exmem_branch),
    .exmem_zero  (exmem_zero),
    .md_start    (md_start),
    .md_is_div   (md_is_div),
    .pc_wr       (pc_wr),
    .ifid_wr     (ifid_wr),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .exmem_bubble(exmem_bubble),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;  // falling edges at 5, 15, ...; rising at 10, 20, ...

  typedef struct packed {
    logic        pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_bubble, md_busy, md_done;
    logic [15:0] stall_cnt, flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  bit   quiet = 1'b0;

  // Reference model: remaining busy cycles plus a pending done flag.
  int          busy_left = 0;
  bit          done_flag = 1'b0;
  logic [15:0] m_stall = '0, m_flush = '0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                     input logic [4:0] t, input logic [5:0] fn);
    return {op, s, t, 10'd0, fn};
  endfunction

  // One pipeline cycle: drive at the rising edge, check, then advance the model.
  task automatic cyc(input logic r, input logic [31:0] instr, input logic [2:0] mr,
                     input logic [4:0] xrt, input logic j, input logic b, input logic z,
                     input logic st, input logic dv);
    exp_t e, g;
    logic lu, mh, br, jp, stl, bsy;
    rst = r; ifid_instr = instr; idex_memread = mr; idex_rt = xrt;
    idex_jump = j; exmem_branch = b; exmem_zero = z; md_start = st; md_is_div = dv;
    if (!r) begin
      busy_left = 0; done_flag = 1'b0; m_stall = '0; m_flush = '0;
    end
    bsy = (busy_left > 0);
    lu  = (mr != 0) && (xrt != 0) && (xrt == instr[25:21] || xrt == instr[20:16]);
    mh  = bsy && instr[31:26] == 6'd0 && instr[5:0] >= 6'h10 && instr[5:0] <= 6'h1B;
    br  = r & b & z;
    jp  = r & j & ~br;
    stl = r & (lu | mh) & ~br & ~jp;
    e.pc_wr = ~stl; e.ifid_wr = ~stl; e.ifid_flush = br | jp;
    e.idex_bubble = br | jp | stl; e.exmem_bubble = br;
    e.md_busy = bsy; e.md_done = done_flag;
    e.stall_cnt = m_stall; e.flush_cnt = m_flush;
    exp_q.push_back(e);
    #2;
    g = exp_q.pop_front();
    if (!quiet) begin
      check_eq("pc_wr", 16'(pc_wr), 16'(g.pc_wr));
      check_eq("ifid_wr", 16'(ifid_wr), 16'(g.ifid_wr));
      check_eq("ifid_flush", 16'(ifid_flush), 16'(g.ifid_flush));
      check_eq("idex_bubble", 16'(idex_bubble), 16'(g.idex_bubble));
      check_eq("exmem_bubble", 16'(exmem_bubble), 16'(g.exmem_bubble));
      check_eq("md_busy", 16'(md_busy), 16'(g.md_busy));
      check_eq("md_done", 16'(md_done), 16'(g.md_done));
      check_eq("stall_cnt", stall_cnt, g.stall_cnt);
      check_eq("flush_cnt", flush_cnt, g.flush_cnt);
    end
    @(negedge clk);
    if (r) begin
      if (stl && m_stall != 16'hFFFF) m_stall++;
      if ((br | jp) && m_flush != 16'hFFFF) m_flush++;
      if (done_flag) done_flag = 1'b0;
      else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) done_flag = 1'b1;
      end else if (st && !br) busy_left = dv ? 32 : 4;
    end
    @(posedge clk);
  endtask

  localparam logic [31:0] Nop = 32'd0;
  logic [31:0] lw_rs8, use_rt8, rs0, mflo, mult;

  initial begin
    lw_rs8  = mk(6'h23, 5'd8, 5'd3, 6'h00);
    use_rt8 = mk(6'h00, 5'd2, 5'd8, 6'h20);
    rs0     = mk(6'h00, 5'd0, 5'd9, 6'h20);
    mflo    = mk(6'h00, 5'd0, 5'd0, 6'h12);
    mult    = mk(6'h00, 5'd4, 5'd5, 6'h18);
    @(posedge clk);
    // Reset state, including a stray load-use and branch while held
    cyc(0, lw_rs8, 3'b001, 5'd8, 0, 1, 1, 1, 0);
    cyc(0, Nop, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, Nop, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs, then on rt, then the non-hazard cases
    cyc(1, lw_rs8, 3'b001, 5'd8, 0, 0, 0, 0, 0);
    cyc(1, use_rt8, 3'b100, 5'd8, 0, 0, 0, 0, 0);
    cyc(1, rs0, 3'b001, 5'd0, 0, 0, 0, 0, 0);
    cyc(1, lw_rs8, 3'b000, 5'd8, 0, 0, 0, 0, 0);
    cyc(1, lw_rs8, 3'b001, 5'd8, 0, 1, 0, 0, 0);  // branch not taken: still stalls
    // Branch and jump override a simultaneous stall
    cyc(1, lw_rs8, 3'b001, 5'd8, 0, 1, 1, 0, 0);
    cyc(1, lw_rs8, 3'b001, 5'd8, 1, 0, 0, 0, 0);
    cyc(1, Nop, 0, 0, 1, 1, 1, 0, 0);
    // md_start squashed by a taken branch
    cyc(1, Nop, 0, 0, 0, 1, 1, 1, 0);
    cyc(1, Nop, 0, 0, 0, 0, 0, 0, 0);
    // Multiply with mflo waiting in ID, with a load-use mixed in
    cyc(1, mult, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, mflo, (i == 1) ? 3'b010 : 3'b000, 5'd0, 0, 0, 0, 0, 0);
    // Divide with a second md_start mid-operation
    cyc(1, Nop, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 36; i++) cyc(1, (i == 20) ? mult : Nop, 0, 0, 0, 0, 0, i == 5, i[0]);
    // Divide abandoned by reset at cycle 10
    cyc(1, Nop, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) cyc(1, lw_rs8, (i == 3) ? 3'b001 : 3'b000, 5'd8, 0, 0, 0, 0, 0);
    cyc(0, Nop, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(1, Nop, 0, 0, 0, 0, 0, 0, 0);
    // Saturation: long run of stalls, checked in full only near the wrap point
    quiet = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      quiet = (i < 4) || (i > 65530);
      cyc(1, lw_rs8, 3'b001, 5'd8, 0, 0, 0, 0, 0);
    end
    quiet = 1'b0;
    cyc(1, Nop, 0, 0, 0, 0, 0, 0, 0);
    check_eq("stall_sat", stall_cnt, 16'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
